dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder: the slave end of the core's data-memory strobe interface.
- Accepts the read/write strobes and byte-lane enables that the multicycle control FSM issues, together with the ALU-computed byte address and the store data.
- Holds a word-organised byte-writable RAM; returns registered read data with a one-cycle ready pulse after a configurable number of wait states.
- Sits between the datapath (address/store data, load data return) and the control FSM.

Parameters:
- ADDR_WIDTH, 10, word-address bits; RAM depth = 2**ADDR_WIDTH 32-bit words.
- WAIT_CYCLES, 0, extra wait states between request acceptance and response (0..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- dMemRead  input  1  read request strobe.
- dMemWrite  input  1  write request strobe.
- dMemByteRead  input  4  byte-lane enables for the read; bit i selects rdata[8i+7:8i].
- dMemByteWrite  input  4  byte-lane enables for the write.
- addr  input  32  byte address; bits [1:0] must be 0.
- wdata  input  32  store data.
- rdata  output  32  load data; lanes not enabled read 0.
- ready  output  1  one-cycle pulse marking completion of a transaction.
- error  output  1  one-cycle pulse, coincident with ready, when the transaction faulted.
- busy  output  1  high from acceptance through the response cycle.

Behaviour:
- Reset (async, immediate): state=IDLE; rdata=0, ready=0, error=0, busy=0; wait counter=0; latched request cleared. A write pending when reset arrives is discarded. RAM contents are not reset.
- FSM states are IDLE, WAIT and RESP.
- IDLE: a request is accepted on a rising edge where dMemRead or dMemWrite is high. On acceptance:
  - latch addr, wdata, both byte-enable vectors and the request type;
  - busy=1 from the next cycle;
  - next state is WAIT if WAIT_CYCLES>0, else RESP.
- WAIT: the counter is loaded with WAIT_CYCLES-1 on entry and decrements each cycle. Move to RESP when it reaches 0. busy=1. Strobe inputs are ignored.
- RESP (exactly one cycle): ready=1, busy=1, then return to IDLE.
  - Read: rdata is driven registered, valid during RESP.
  - Write: RAM lanes with dMemByteWrite=1 are updated at the rising edge that ends RESP. Lanes with 0 are unchanged.
- Latency: with WAIT_CYCLES=N, ready rises N+1 cycles after the accepting edge. With N=0, a strobe held for one cycle returns data the next cycle.
- rdata holds its value after RESP until the next read response. Write and error responses drive rdata=0.
- Fault conditions, checked on the latched request:
  - addr[1:0]!=0;
  - addr[31:ADDR_WIDTH+2]!=0 (out of range);
  - dMemRead and dMemWrite both high;
  - the enable vector for the selected operation is all zero.
- Fault response: error=1 together with ready in RESP; no RAM update; rdata=0. The same wait-state timing applies.
- Strobes are level-sampled only in IDLE. A strobe still high in the cycle after RESP starts a new transaction; the initiator deasserts before then. A repeated store is idempotent.
- Lane mapping is little-endian: lane 0 = addr+0 = bits [7:0].
- Read-during-write cannot occur, because only one transaction is in flight.

Decomposition:
- Shared package:
  - state encoding (IDLE, WAIT, RESP, 2 bits);
  - BYTE_LANES=4 and LANE_WIDTH=8;
  - operation type encoding (OP_READ, OP_WRITE);
  - the fault-cause list, for use in assertions.
- One sub-module, dmem_byte_ram:
  - parameter ADDR_WIDTH;
  - synchronous write with 4-bit lane enable;
  - registered read;
  - no reset on the array.
- The FSM, wait counter, fault checks and output lane masking stay in dmem_responder.

Test Plan:
- WAIT_CYCLES=0: write addr=0x10, wdata=0xDEADBEEF, byteWrite=4'b1111; then read addr=0x10, byteRead=4'b1111 -> ready one cycle after each accept, rdata=0xDEADBEEF, error=0.
- Partial write: addr=0x10 holds 0xDEADBEEF; write wdata=0x11223344, byteWrite=4'b0101; read with byteRead=4'b1111 -> rdata=0xDE22BE44. Read with byteRead=4'b0011 -> rdata=0x0000BE44.
- WAIT_CYCLES=3: read strobe at cycle 0 -> busy=1 in cycles 1..4, ready exactly in cycle 4, strobes pulsed in cycles 1..3 ignored.
- Faults: read addr=0x12 -> ready=1, error=1, rdata=0. Write addr=0x1000 with ADDR_WIDTH=10 -> error=1 and RAM word 0 unchanged. Read and write strobes high together -> error=1, no write.
- Reset mid-operation: WAIT_CYCLES=3, write accepted, rst asserted asynchronously in cycle 2 -> outputs 0 immediately, state IDLE, no ready pulse, target word unchanged.
- Back-to-back: strobe held high for 4 cycles with WAIT_CYCLES=0 -> two transactions, ready in cycles 1 and 3, busy low in cycle 2.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM states, lane geometry,
// request type and the list of fault causes.
`timescale 1ns/1ps
package dmem_responder_pkg;

   localparam int unsigned BYTE_LANES = 4;
   localparam int unsigned LANE_WIDTH = 8;
   localparam int unsigned DATA_WIDTH = BYTE_LANES * LANE_WIDTH;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } stateT;

   typedef enum logic {
      OP_READ  = 1'b0,
      OP_WRITE = 1'b1
   } opT;

   typedef enum logic [2:0] {
      FAULT_NONE       = 3'd0,
      FAULT_MISALIGNED = 3'd1,
      FAULT_RANGE      = 3'd2,
      FAULT_CONFLICT   = 3'd3,
      FAULT_NO_LANES   = 3'd4
   } faultT;

   // Expand a byte-lane enable vector into a full-width data mask.
   function automatic logic [DATA_WIDTH-1:0] laneMask(input logic [BYTE_LANES-1:0] en);
      logic [DATA_WIDTH-1:0] m;
      m = '0;
      for (int unsigned i = 0; i < BYTE_LANES; i++) begin
         m[i*LANE_WIDTH +: LANE_WIDTH] = {LANE_WIDTH{en[i]}};
      end
      return m;
   endfunction

   // Classify a latched request; the first matching cause wins.
   function automatic faultT faultCause(
      input logic [31:0]           addr,
      input int unsigned           addrWidth,
      input logic                  conflict,
      input opT                    op,
      input logic [BYTE_LANES-1:0] rdLanes,
      input logic [BYTE_LANES-1:0] wrLanes
   );
      if (addr[1:0] != 2'b00)
         return FAULT_MISALIGNED;
      if ((addr >> (addrWidth + 32'd2)) != 32'd0)
         return FAULT_RANGE;
      if (conflict)
         return FAULT_CONFLICT;
      if (op == OP_WRITE ? (wrLanes == '0) : (rdLanes == '0))
         return FAULT_NO_LANES;
      return FAULT_NONE;
   endfunction

endpackage

// File: rtl/dmem_byte_ram.sv
// Word-organised, byte-writable RAM with a registered read port.
// The array is deliberately not reset.
`timescale 1ns/1ps
module dmem_byte_ram
   import dmem_responder_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  wrEn,
   input  logic [BYTE_LANES-1:0] laneEn,
   input  logic [ADDR_WIDTH-1:0] wordAddr,
   input  logic [DATA_WIDTH-1:0] wrData,
   output logic [DATA_WIDTH-1:0] rdData
);

   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

   // Lane-masked synchronous write and registered read of the addressed word.
   always_ff @(posedge clk) begin
      if (wrEn) begin
         for (int unsigned i = 0; i < BYTE_LANES; i++) begin
            if (laneEn[i])
               mem[wordAddr][i*LANE_WIDTH +: LANE_WIDTH] <= wrData[i*LANE_WIDTH +: LANE_WIDTH];
         end
      end
      rdData <= mem[wordAddr];
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one strobed request at a time, waits
// WAIT_CYCLES, then answers with a one-cycle ready (and error on faults).
`timescale 1ns/1ps
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH  = 10,
   parameter int unsigned WAIT_CYCLES = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  dMemRead,
   input  logic                  dMemWrite,
   input  logic [BYTE_LANES-1:0] dMemByteRead,
   input  logic [BYTE_LANES-1:0] dMemByteWrite,
   input  logic [31:0]           addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  ready,
   output logic                  error,
   output logic                  busy
);

   localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   stateT                 state, nextState;
   logic                  accept;
   logic [3:0]            waitCnt;

   opT                    reqOp;
   logic                  reqConflict;
   logic [BYTE_LANES-1:0] reqRdLanes, reqWrLanes;
   logic [31:0]           reqAddr;
   logic [DATA_WIDTH-1:0] reqWdata;

   faultT                 cause;
   logic                  fault;
   logic                  ramWe;
   logic [ADDR_WIDTH-1:0] ramAddr;
   logic [DATA_WIDTH-1:0] ramQ;
   logic [DATA_WIDTH-1:0] respData, rdataHold;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= nextState;
   end

   // Next-state logic; strobes only matter while idle.
   always_comb begin
      nextState = state;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            if (dMemRead || dMemWrite) begin
               accept    = 1'b1;
               nextState = (WAIT_CYCLES > 0) ? WAIT : RESP;
            end
         end
         WAIT:    if (waitCnt == '0) nextState = RESP;
         RESP:    nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // Wait-state counter: loaded on entry to WAIT, counts down to zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         waitCnt <= '0;
      else if (nextState == WAIT && state != WAIT)
         waitCnt <= WAIT_LOAD;
      else if (state == WAIT && waitCnt != '0)
         waitCnt <= waitCnt - 4'd1;
   end

   // Capture the request on acceptance; held for the whole transaction.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         reqOp       <= OP_READ;
         reqConflict <= 1'b0;
         reqRdLanes  <= '0;
         reqWrLanes  <= '0;
         reqAddr     <= '0;
         reqWdata    <= '0;
      end else if (accept) begin
         reqOp       <= dMemWrite ? OP_WRITE : OP_READ;
         reqConflict <= dMemRead && dMemWrite;
         reqRdLanes  <= dMemByteRead;
         reqWrLanes  <= dMemByteWrite;
         reqAddr     <= addr;
         reqWdata    <= wdata;
      end
   end

   // Fault classification, RAM control and response data.
   // While idle the RAM is addressed straight from the bus so that a zero-wait
   // read has its word registered by the accepting edge.
   always_comb begin
      cause    = faultCause(reqAddr, ADDR_WIDTH, reqConflict, reqOp, reqRdLanes, reqWrLanes);
      fault    = (cause != FAULT_NONE);
      ramAddr  = (state == IDLE) ? addr[ADDR_WIDTH+1:2] : reqAddr[ADDR_WIDTH+1:2];
      ramWe    = (state == RESP) && (reqOp == OP_WRITE) && !fault;
      respData = (reqOp == OP_READ && !fault) ? (ramQ & laneMask(reqRdLanes)) : '0;
   end

   // Keep the last response word on rdata between transactions.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         rdataHold <= '0;
      else if (state == RESP)
         rdataHold <= respData;
   end

   // Output decode.
   always_comb begin
      ready = (state == RESP);
      error = (state == RESP) && fault;
      busy  = (state != IDLE);
      rdata = (state == RESP) ? respData : rdataHold;
   end

   dmem_byte_ram #(
      .ADDR_WIDTH(ADDR_WIDTH)
   ) u_ram (
      .clk     (clk),
      .wrEn    (ramWe),
      .laneEn  (reqWrLanes),
      .wordAddr(ramAddr),
      .wrData  (reqWdata),
      .rdData  (ramQ)
   );

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: a zero-wait and a three-wait
// instance, directed scenarios followed by randomized traffic against a
// word-array reference model.
`timescale 1ns/1ps
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b0;

   logic        rd0 = 1'b0, wr0 = 1'b0, rd1 = 1'b0, wr1 = 1'b0;
   logic [3:0]  br0 = '0, bw0 = '0, br1 = '0, bw1 = '0;
   logic [31:0] ad0 = '0, wd0 = '0, ad1 = '0, wd1 = '0;
   logic [31:0] rdata0, rdata1;
   logic        ready0, ready1, error0, error1, busy0, busy1;

   int checks   = 0;
   int failures = 0;

   // Reference memory, keyed by dut*4096 + word index.
   logic [31:0] mdl [int];

   always #5 clk = ~clk;

   dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .rst(rst), .dMemRead(rd0), .dMemWrite(wr0),
      .dMemByteRead(br0), .dMemByteWrite(bw0), .addr(ad0), .wdata(wd0),
      .rdata(rdata0), .ready(ready0), .error(error0), .busy(busy0));

   dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(3)) dut1 (
      .clk(clk), .rst(rst), .dMemRead(rd1), .dMemWrite(wr1),
      .dMemByteRead(br1), .dMemByteWrite(bw1), .addr(ad1), .wdata(wd1),
      .rdata(rdata1), .ready(ready1), .error(error1), .busy(busy1));

   function automatic logic [31:0] rdataOf(input int d);  return (d == 0) ? rdata0 : rdata1; endfunction
   function automatic logic        readyOf(input int d);  return (d == 0) ? ready0 : ready1; endfunction
   function automatic logic        errorOf(input int d);  return (d == 0) ? error0 : error1; endfunction
   function automatic logic        busyOf(input int d);   return (d == 0) ? busy0  : busy1;  endfunction
   function automatic int unsigned waitsOf(input int d);  return (d == 0) ? 0 : 3;           endfunction

   // Fault rule from the interface description: misaligned, beyond 1024 words,
   // both strobes, or no lanes enabled for the chosen operation.
   function automatic bit modelFault(input logic r, input logic w, input logic [3:0] brv,
                                     input logic [3:0] bwv, input logic [31:0] a);
      return (a % 4 != 0) || (a >= 32'd4096) || (r && w) || (r ? (brv == 0) : (bwv == 0));
   endfunction

   function automatic logic [31:0] keepBytes(input logic [31:0] v, input logic [3:0] en);
      logic [31:0] o;
      o = 0;
      for (int i = 0; i < 4; i++)
         if (en[i]) o = o | (v & (32'hFF << (8 * i)));
      return o;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int d, input logic r, input logic w, input logic [3:0] brv,
                        input logic [3:0] bwv, input logic [31:0] a, input logic [31:0] wdv);
      if (d == 0) begin
         rd0 = r; wr0 = w; br0 = brv; bw0 = bwv; ad0 = a; wd0 = wdv;
      end else begin
         rd1 = r; wr1 = w; br1 = brv; bw1 = bwv; ad1 = a; wd1 = wdv;
      end
   endtask

   // One complete transaction: pulse the strobe for one cycle, optionally
   // toggle random strobes during the wait states, then check the response.
   task automatic txn(input int d, input logic r, input logic w, input logic [3:0] brv,
                      input logic [3:0] bwv, input logic [31:0] a, input logic [31:0] wdv,
                      input bit noise, input string tag);
      bit          f;
      logic [31:0] expData;
      int          key;
      f       = modelFault(r, w, brv, bwv, a);
      key     = d * 4096 + int'(a >> 2);
      expData = 0;
      if (!f && r) expData = keepBytes(mdl[key], brv);
      if (!f && w) mdl[key] = (mdl[key] & ~keepBytes(32'hFFFF_FFFF, bwv)) | keepBytes(wdv, bwv);

      drive(d, r, w, brv, bwv, a, wdv);
      @(posedge clk); #1;
      drive(d, 0, 0, 0, 0, 0, 0);
      for (int unsigned k = 0; k < waitsOf(d); k++) begin
         if (noise)
            drive(d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom),
                  4'($urandom), 32'($urandom_range(0, 15)) * 4, $urandom);
         @(negedge clk);
         check($sformatf("%s.wait%0d.ready", tag, k), 32'(readyOf(d)), 0);
         check($sformatf("%s.wait%0d.busy", tag, k), 32'(busyOf(d)), 1);
         @(posedge clk); #1;
         drive(d, 0, 0, 0, 0, 0, 0);
      end
      @(negedge clk);
      check({tag, ".ready"}, 32'(readyOf(d)), 1);
      check({tag, ".busy"},  32'(busyOf(d)), 1);
      check({tag, ".error"}, 32'(errorOf(d)), 32'(f));
      check({tag, ".rdata"}, rdataOf(d), expData);
      @(negedge clk);
      check({tag, ".idleReady"}, 32'(readyOf(d)), 0);
      check({tag, ".idleBusy"},  32'(busyOf(d)), 0);
      if (!f && r) check({tag, ".rdataHeld"}, rdataOf(d), expData);
   endtask

   // Hard stop should the bench ever stall.
   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state.
      #1 rst = 1'b1;
      #1;
      check("rst.ready0", 32'(ready0), 0); check("rst.busy0", 32'(busy0), 0);
      check("rst.error0", 32'(error0), 0); check("rst.rdata0", rdata0, 0);
      check("rst.ready1", 32'(ready1), 0); check("rst.busy1", 32'(busy1), 0);
      check("rst.error1", 32'(error1), 0); check("rst.rdata1", rdata1, 0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;

      // Fill words 0..15 of both instances so every later read is defined.
      for (int d = 0; d < 2; d++)
         for (int i = 0; i < 16; i++)
            txn(d, 0, 1, 4'h0, 4'hF, 32'(i * 4), $urandom, 0, $sformatf("fill%0d_%0d", d, i));

      // Zero-wait full write and read back.
      txn(0, 0, 1, 4'h0, 4'hF, 32'h10, 32'hDEAD_BEEF, 0, "w0.full");
      txn(0, 1, 0, 4'hF, 4'h0, 32'h10, 32'h0, 0, "r0.full");
      check("r0.fullConst", rdata0, 32'hDEAD_BEEF);

      // Partial write, then full and partial reads.
      txn(0, 0, 1, 4'h0, 4'b0101, 32'h10, 32'h1122_3344, 0, "w0.partial");
      txn(0, 1, 0, 4'hF, 4'h0, 32'h10, 32'h0, 0, "r0.partial");
      check("r0.partialConst", rdata0, 32'hDE22_BE44);
      txn(0, 1, 0, 4'b0011, 4'h0, 32'h10, 32'h0, 0, "r0.lanes");
      check("r0.lanesConst", rdata0, 32'h0000_BE44);

      // Faults: misaligned read, out-of-range write, both strobes, no lanes.
      txn(0, 0, 1, 4'h0, 4'hF, 32'h0, 32'hCAFE_F00D, 0, "w0.word0");
      txn(0, 1, 0, 4'hF, 4'h0, 32'h12, 32'h0, 0, "f0.misaligned");
      txn(0, 0, 1, 4'h0, 4'hF, 32'h1000, 32'h5555_5555, 0, "f0.range");
      txn(0, 1, 1, 4'hF, 4'hF, 32'h0, 32'h1234_5678, 0, "f0.conflict");
      txn(0, 1, 0, 4'h0, 4'h0, 32'h0, 32'h0, 0, "f0.noLanes");
      txn(0, 1, 0, 4'hF, 4'h0, 32'h0, 32'h0, 0, "r0.word0");
      check("r0.word0Const", rdata0, 32'hCAFE_F00D);

      // Three wait states with strobe noise during the wait.
      txn(1, 0, 1, 4'h0, 4'hF, 32'h10, 32'h0BAD_F00D, 1, "w1.full");
      txn(1, 1, 0, 4'hF, 4'h0, 32'h10, 32'h0, 1, "r1.full");
      check("r1.fullConst", rdata1, 32'h0BAD_F00D);

      // Reset in the second wait cycle of a write: no response, word kept.
      txn(1, 0, 1, 4'h0, 4'hF, 32'h20, 32'hA5A5_A5A5, 0, "w1.pre");
      drive(1, 0, 1, 4'h0, 4'hF, 32'h20, 32'hFFFF_FFFF);
      @(posedge clk); #1;
      drive(1, 0, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      check("rstMid.busyBefore", 32'(busy1), 1);
      #2 rst = 1'b1;
      #1;
      check("rstMid.busy", 32'(busy1), 0);
      check("rstMid.ready", 32'(ready1), 0);
      check("rstMid.error", 32'(error1), 0);
      check("rstMid.rdata", rdata1, 0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check($sformatf("rstMid.noReady%0d", k), 32'(ready1), 0);
      end
      txn(1, 1, 0, 4'hF, 4'h0, 32'h20, 32'h0, 0, "rstMid.readBack");
      check("rstMid.readBackConst", rdata1, 32'hA5A5_A5A5);

      // Strobe held four cycles at zero wait: two transactions.
      drive(0, 1, 0, 4'hF, 4'h0, 32'hC, 32'h0);
      @(posedge clk); @(negedge clk);
      check("b2b.ready1", 32'(ready0), 1);
      check("b2b.rdata1", rdata0, mdl[3]);
      @(posedge clk); @(negedge clk);
      check("b2b.gapBusy", 32'(busy0), 0);
      check("b2b.gapReady", 32'(ready0), 0);
      @(posedge clk); @(negedge clk);
      check("b2b.ready2", 32'(ready0), 1);
      check("b2b.rdata2", rdata0, mdl[3]);
      @(posedge clk); #1;
      drive(0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      check("b2b.endBusy", 32'(busy0), 0);
      @(negedge clk);
      check("b2b.endReady", 32'(ready0), 0);

      // Randomized traffic against the reference model.
      for (int n = 0; n < 80; n++) begin
         int          d, kind;
         logic        r, w;
         logic [3:0]  brv, bwv;
         logic [31:0] a;
         d    = $urandom_range(0, 1);
         kind = $urandom_range(0, 9);
         r    = 1'($urandom_range(0, 1));
         w    = !r;
         brv  = 4'($urandom);
         bwv  = 4'($urandom);
         a    = 32'($urandom_range(0, 15)) * 4;
         case (kind)
            0: a = a + 32'($urandom_range(1, 3));
            1: a = ($urandom_range(0, 1) != 0) ? (a | 32'h8000_0000) : (a + 32'h1000);
            2: begin r = 1; w = 1; end
            3: begin brv = 0; bwv = 0; end
            default: ;
         endcase
         txn(d, r, w, brv, bwv, a, $urandom, d == 1, $sformatf("rand%0d", n));
      end

      // Final sweep: every modelled word must match.
      for (int d = 0; d < 2; d++)
         for (int i = 0; i < 16; i++)
            txn(d, 1, 0, 4'hF, 4'h0, 32'(i * 4), 32'h0, 0, $sformatf("sweep%0d_%0d", d, i));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
